// File: rtl/div_sched.sv
// Sequencer sharing one unsigned 32-bit divider core across div.w/mod.w/div.wu/mod.wu.
// Handshakes: a transfer happens on any cycle where valid & ready are both high; valid holds until then (except on cancel).
module div_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        cancel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy,
  output logic        core_in_valid,
  input  logic        core_in_ready,
  output logic [31:0] core_dividend,
  output logic [31:0] core_divisor,
  input  logic        core_out_valid,
  input  logic [31:0] core_quot,
  input  logic [31:0] core_rem,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        is_quot_q, is_quot_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] result_q, result_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        resp_valid_q;
  logic        core_in_valid_q;
  logic        busy_q;

  logic        req_fire;
  logic        req_signed;
  logic        req_is_quot;
  logic [31:0] core_result;

  assign req_ready   = (state_q == S_IDLE) & ~cancel;
  assign req_fire    = req_valid & req_ready;
  assign req_signed  = req_op[0] | req_op[1];
  assign req_is_quot = (req_op[0] | req_op[2]) & ~(req_op[1] | req_op[3]);

  // Sign correction of the unsigned core result; negation wraps, so 0x80000000 stays put.
  assign core_result = is_quot_q ? (qneg_q ? 32'd0 - core_quot : core_quot)
                                 : (rneg_q ? 32'd0 - core_rem  : core_rem);

  always_comb begin
    state_d    = state_q;
    is_quot_d  = is_quot_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    result_d   = result_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          is_quot_d  = req_is_quot;
          qneg_d     = req_signed & (req_src1[31] ^ req_src2[31]);
          rneg_d     = req_signed & req_src1[31];
          dividend_d = (req_signed & req_src1[31]) ? 32'd0 - req_src1 : req_src1;
          divisor_d  = (req_signed & req_src2[31]) ? 32'd0 - req_src2 : req_src2;
          if (req_src2 == 32'd0) begin
            state_d  = S_DONE;
            result_d = req_is_quot ? 32'hFFFF_FFFF : req_src1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Once the core has taken operands its result must be drained, even on cancel.
        if (cancel)             state_d = core_in_ready ? S_DRAIN : S_IDLE;
        else if (core_in_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cancel) begin
          state_d = core_out_valid ? S_IDLE : S_DRAIN;
        end else if (core_out_valid) begin
          state_d  = S_DONE;
          result_d = core_result;
        end
      end
      S_DONE: begin
        if (cancel || resp_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (core_out_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      is_quot_q       <= 1'b0;
      qneg_q          <= 1'b0;
      rneg_q          <= 1'b0;
      result_q        <= 32'd0;
      dividend_q      <= 32'd0;
      divisor_q       <= 32'd0;
      resp_valid_q    <= 1'b0;
      core_in_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_quot_q       <= is_quot_d;
      qneg_q          <= qneg_d;
      rneg_q          <= rneg_d;
      result_q        <= result_d;
      dividend_q      <= dividend_d;
      divisor_q       <= divisor_d;
      resp_valid_q    <= (state_d == S_DONE);
      core_in_valid_q <= (state_d == S_ISSUE);
      busy_q          <= (state_d != S_IDLE);
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_result   = result_q;
  assign busy          = busy_q;
  assign core_in_valid = core_in_valid_q;
  assign core_dividend = dividend_q;
  assign core_divisor  = divisor_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: latency-8 core model with random accept stalls, result scoreboard,
// directed sign/overflow/div-by-zero/backpressure/cancel/reset cases and a random run.
module tb_div_sched;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam int         LAT     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'b0001;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        cancel = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;
  logic        busy;
  logic        core_in_valid;
  logic        core_in_ready = 1'b0;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_out_valid = 1'b0;
  logic [31:0] core_quot = '0;
  logic [31:0] core_rem = '0;
  logic [2:0]  dbg_state;

  div_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .cancel(cancel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .busy(busy),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_out_valid(core_out_valid), .core_quot(core_quot), .core_rem(core_rem),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- core model (drives at negedge+1) ----------------
  int          force_stall = -1;
  int          stall = 0;
  int          lat = 0;
  bit          armed = 0;
  int          pulse_cnt = 0;
  logic [31:0] pq = '0, pr = '0;

  always begin
    @(negedge clk); #1;
    core_out_valid = 1'b0;
    core_in_ready  = 1'b0;
    if (reset) begin
      lat = 0; armed = 0;
    end else begin
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          core_out_valid = 1'b1; core_quot = pq; core_rem = pr; pulse_cnt++;
        end
      end
      if (!core_in_valid) armed = 0;
      else begin
        if (!armed) begin
          armed = 1;
          stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
        end
        if (stall == 0) begin
          core_in_ready = 1'b1; armed = 0; lat = LAT;
          pq = core_dividend / core_divisor;
          pr = core_dividend % core_divisor;
        end else stall--;
      end
    end
  end

  // ---------------- scoreboard / monitor (samples at negedge+2) ----------------
  logic [31:0] exp_q[$];
  int          resp_cnt = 0;
  int          issue_cnt = 0;
  int          rise_cyc = 0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_result = '0;

  always begin
    @(negedge clk); #2;
    if (!reset) begin
      if (resp_valid && !prev_valid) rise_cyc = cyc;
      if (resp_valid && prev_valid && !prev_ready) check("resp_stable", resp_result, prev_result);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", 32'(exp_q.size()), 32'd1);
        else check("resp_data", resp_result, exp_q.pop_front());
        resp_cnt++;
      end
      if (core_in_valid) issue_cnt++;
      if (core_out_valid)
        check("core_pulse_state", 32'(dbg_state == S_WAIT || dbg_state == S_DRAIN), 32'd1);
    end
    prev_valid  = resp_valid;
    prev_ready  = resp_ready;
    prev_result = resp_result;
  end

  // ---------------- driver tasks (called at negedge) ----------------
  int acc_cyc = 0;
  bit rand_ready = 0;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return (op[0] | op[2]) ? 32'hFFFF_FFFF : a;
    if (op[2]) return a / b;
    if (op[3]) return a % b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'h8000_0000 : 32'd0;
    if (op[0]) return 32'(sa / sb);
    return 32'(sa % sb);
  endfunction

  task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] exp);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    #1;
    while (!req_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'd1);
    acc_cyc = cyc;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start);
    int n = 0;
    while (resp_cnt == start && n < 200) begin
      @(negedge clk);
      if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (resp_cnt == start) check("resp_timeout", 32'(resp_cnt), 32'(start + 1));
    resp_ready = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int start = resp_cnt;
    do_req(op, a, b, 1, exp);
    wait_resp(start);
    if (exp_lat > 0) check(tag, 32'(rise_cyc - acc_cyc), 32'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start, pc, ic, n, hcyc;
    logic [3:0]  op;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_core_in_valid", 32'(core_in_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dividend", core_dividend, 32'd0);
    check("rst_divisor", core_divisor, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Signed/unsigned values and overflow, no stall: result visible 10 cycles after accept.
    force_stall = 0;
    run_op("lat_div_w", 4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10);
    @(negedge clk);
    run_op("lat_mod_w", 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 10);
    run_op("lat_div_wu", 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 10);
    run_op("lat_mod_wu", 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'd1, 10);
    run_op("lat_ovf_div", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 10);
    run_op("lat_ovf_mod", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 10);

    // Divide by zero never touches the core.
    ic = issue_cnt;
    run_op("lat_div0_div_w", 4'b0001, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("lat_div0_mod_wu", 4'b1000, 32'd5, 32'd0, 32'd5, 1);
    check("div0_no_issue", 32'(issue_cnt), 32'(ic));

    // Cancel while idle rejects the request.
    req_valid = 1'b1; req_op = 4'b0001; req_src1 = 32'd9; req_src2 = 32'd3; cancel = 1'b1;
    #1;
    check("cancel_idle_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; cancel = 1'b0;
    #3;
    check("cancel_idle_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);

    // Backpressure in DONE.
    force_stall = -1;
    resp_ready  = 1'b0;
    start = resp_cnt;
    do_req(4'b0100, 32'd1000, 32'd7, 1, 32'd142);
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_resp_valid", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_op = 4'b1000; req_src1 = 32'd1000; req_src2 = 32'd7;
      #1;
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_state", 32'(dbg_state), 32'(S_DONE));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_hs_req_ready", 32'(req_ready), 32'd0);
    hcyc = cyc;
    @(negedge clk);
    check("bp_first_popped", 32'(resp_cnt), 32'(start + 1));
    start = resp_cnt;
    do_req(4'b1000, 32'd1000, 32'd7, 1, 32'd6);
    check("bp_next_accept_cyc", 32'(acc_cyc), 32'(hcyc + 1));
    wait_resp(start);

    // Cancel in WAIT at cycle 4: drain the core pulse at cycle 9, idle at cycle 10.
    force_stall = 0;
    start = resp_cnt;
    pc = pulse_cnt;
    do_req(4'b0001, 32'd100, 32'd7, 0, 32'd0);
    while (cyc < acc_cyc + 4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #3;
    check("cancel_wait_drain", 32'(dbg_state), 32'(S_DRAIN));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #3;
      check("drain_no_resp", 32'(resp_valid), 32'd0);
    end
    check("drain_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #3;
    check("drain_done_ready", 32'(req_ready), 32'd1);
    check("drain_pulse_seen", 32'(pulse_cnt), 32'(pc + 1));
    check("drain_no_output", 32'(resp_cnt), 32'(start));
    @(negedge clk);
    run_op("lat_after_drain", 4'b0001, 32'd100, 32'd7, 32'd14, 10);

    // Cancel in ISSUE while the core stalls.
    force_stall = 5;
    start = resp_cnt;
    pc = pulse_cnt;
    do_req(4'b0010, 32'hFFFF_FF00, 32'd3, 0, 32'd0);
    #3;
    check("issue_in_valid", 32'(core_in_valid), 32'd1);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #3;
    check("cancel_issue_in_valid", 32'(core_in_valid), 32'd0);
    check("cancel_issue_state", 32'(dbg_state), 32'(S_IDLE));
    check("cancel_issue_busy", 32'(busy), 32'd0);
    repeat (15) @(negedge clk);
    check("cancel_issue_no_pulse", 32'(pulse_cnt), 32'(pc));
    check("cancel_issue_no_resp", 32'(resp_cnt), 32'(start));

    // Reset in WAIT.
    force_stall = 0;
    pc = pulse_cnt;
    do_req(4'b0001, 32'd77, 32'd5, 0, 32'd0);
    @(negedge clk);
    #3;
    check("pre_reset_wait", 32'(dbg_state), 32'(S_WAIT));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    check("wrst_req_ready", 32'(req_ready), 32'd1);
    check("wrst_resp_valid", 32'(resp_valid), 32'd0);
    check("wrst_resp_result", resp_result, 32'd0);
    check("wrst_core_in_valid", 32'(core_in_valid), 32'd0);
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_dividend", core_dividend, 32'd0);
    check("wrst_divisor", core_divisor, 32'd0);
    repeat (12) @(negedge clk);
    check("wrst_no_pulse", 32'(pulse_cnt), 32'(pc));

    // Random ops with random stalls and response backpressure.
    force_stall = -1;
    rand_ready  = 1;
    for (int i = 0; i < 40; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 100));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, model(op, a, b), 0);
    end
    rand_ready = 0;

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
